// File: rtl/or3_req_arbiter_if.sv
// Request/grant bundle between three requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface or3_req_arbiter_if;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;
  logic       any_req;

  modport master (output req, input grant, grant_id, busy, timeout, any_req);
  modport slave  (input req, output grant, grant_id, busy, timeout, any_req);
endinterface

// File: rtl/or3_req_arbiter.sv
// Three-way round-robin arbiter with per-line request polarity and a hold-time limit.
// Grant, owner ID, busy and timeout are registered; any_req is the raw OR of effective requests.
module or3_req_arbiter #(
  parameter logic [2:0]  BubblesMask = 3'b000,
  parameter int unsigned HOLD_MAX    = 15
) (
  input logic               sysclk,
  input logic               sys_rst_n,
  or3_req_arbiter_if.slave  bus
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  localparam bit         HOLD_EN  = (HOLD_MAX != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] gid_q, gid_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [2:0] ereq;
  logic [1:0] winner;

  assign ereq = bus.req ^ BubblesMask;

  // Scan starts one past the last owner so the previous winner ranks lowest.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = 2'd0;
    found = 1'b0;
    idx   = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return w;
  endfunction

  assign winner = pick(ereq, last_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gid_d     = gid_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ereq != 3'b000) begin
          state_d = GRANT;
          grant_d = 3'b001 << winner;
          gid_d   = winner;
          last_d  = winner;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (!ereq[gid_q]) begin
          state_d = RELEASE;
          grant_d = 3'b000;
        end else if (HOLD_EN && hold_q == HOLD_LIM) begin
          state_d   = RELEASE;
          grant_d   = 3'b000;
          timeout_d = 1'b1;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      gid_q     <= 2'd0;
      last_q    <= 2'd2;
      hold_q    <= 8'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gid_q     <= gid_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;
  assign bus.any_req  = |ereq;

endmodule

// File: tb/tb_or3_req_arbiter.sv
// Directed checks of the three-way arbiter across polarity and hold-limit variants.
module tb_or3_req_arbiter;
  logic sysclk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   total = 0;
  int   bad   = 0;

  always #5 sysclk = ~sysclk;

  or3_req_arbiter_if ifa ();
  or3_req_arbiter_if ifb ();
  or3_req_arbiter_if ifc ();

  or3_req_arbiter #(.BubblesMask(3'b000), .HOLD_MAX(15)) dut_a (.sysclk(sysclk), .sys_rst_n(rst_a), .bus(ifa));
  or3_req_arbiter #(.BubblesMask(3'b010), .HOLD_MAX(4))  dut_b (.sysclk(sysclk), .sys_rst_n(rst_b), .bus(ifb));
  or3_req_arbiter #(.BubblesMask(3'b000), .HOLD_MAX(0))  dut_c (.sysclk(sysclk), .sys_rst_n(rst_c), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    logic [2:0] oh;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ifa.req = 3'b000; ifb.req = 3'b010; ifc.req = 3'b000;
    #2;
    chk("rst_grant", 32'(ifa.grant), 0);
    chk("rst_gid",   32'(ifa.grant_id), 0);
    chk("rst_busy",  32'(ifa.busy), 0);
    chk("rst_tmo",   32'(ifa.timeout), 0);
    #10;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Round robin with all three requesting, each owner drops after 3 grant cycles
    ifa.req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      oh = 3'b001 << (r % 3);
      for (int c = 0; c < 3; c++) begin
        tick();
        chk($sformatf("rr%0d_grant", r), 32'(ifa.grant), 32'(oh));
        chk($sformatf("rr%0d_gid", r),   32'(ifa.grant_id), 32'(r % 3));
        chk($sformatf("rr%0d_busy", r),  32'(ifa.busy), 1);
      end
      ifa.req[r % 3] = 1'b0;
      tick();
      chk($sformatf("rr%0d_gap1", r), 32'(ifa.grant), 0);
      chk($sformatf("rr%0d_tmo", r),  32'(ifa.timeout), 0);
      chk($sformatf("rr%0d_idhold", r), 32'(ifa.grant_id), 32'(r % 3));
      ifa.req = 3'b111;
      tick();
      chk($sformatf("rr%0d_gap2", r), 32'(ifa.grant), 0);
      chk($sformatf("rr%0d_busy0", r), 32'(ifa.busy), 0);
    end

    // Async reset in the middle of a tenure
    ifa.req = 3'b000;
    tick(); tick(); tick();
    ifa.req = 3'b001;
    tick();
    chk("pre_rst_grant", 32'(ifa.grant), 32'h1);
    tick();
    #2;
    rst_a = 1'b0;
    #1;
    chk("async_grant", 32'(ifa.grant), 0);
    chk("async_busy",  32'(ifa.busy), 0);
    chk("async_tmo",   32'(ifa.timeout), 0);
    ifa.req = 3'b110;
    tick();
    chk("in_rst_grant", 32'(ifa.grant), 0);
    #3;
    rst_a = 1'b1;
    tick();
    chk("post_rst_grant", 32'(ifa.grant), 32'b010);
    chk("post_rst_gid",   32'(ifa.grant_id), 1);

    // Short pulse from requester 1 while 0 owns must be lost
    ifa.req = 3'b000;
    tick(); tick(); tick();
    ifa.req = 3'b001;
    tick();
    chk("pulse_own", 32'(ifa.grant), 32'b001);
    ifa.req = 3'b011;
    tick();
    ifa.req = 3'b001;
    tick(); tick();
    ifa.req = 3'b000;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("pulse_lost", 32'(ifa.grant[1]), 0);
    end

    // Active-low line 1: req=010 means nothing requested
    tick(); tick();
    chk("inv_any0",   32'(ifb.any_req), 0);
    chk("inv_grant0", 32'(ifb.grant), 0);
    ifb.req = 3'b000;
    #1;
    chk("inv_any1", 32'(ifb.any_req), 1);
    chk("inv_nogrant_yet", 32'(ifb.grant), 0);
    tick();
    chk("inv_grant", 32'(ifb.grant), 32'b010);
    ifb.req = 3'b010;
    tick(); tick();

    // Hold limit 4: requester 0 held, requester 2 waiting
    rst_b = 1'b0;
    #1;
    rst_b = 1'b1;
    ifb.req = 3'b111;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("hold_grant", 32'(ifb.grant), 32'b001);
      chk("hold_tmo0",  32'(ifb.timeout), 0);
    end
    tick();
    chk("hold_rel_grant", 32'(ifb.grant), 0);
    chk("hold_tmo1",      32'(ifb.timeout), 1);
    tick();
    chk("hold_idle_tmo", 32'(ifb.timeout), 0);
    chk("hold_idle_grant", 32'(ifb.grant), 0);
    tick();
    chk("hold_next_grant", 32'(ifb.grant), 32'b100);
    chk("hold_next_gid",   32'(ifb.grant_id), 2);

    // No hold limit: 300-cycle tenure, counter saturates
    ifc.req = 3'b001;
    tick();
    for (int c = 0; c < 300; c++) begin
      chk("nolim_grant", 32'(ifc.grant), 32'b001);
      chk("nolim_tmo",   32'(ifc.timeout), 0);
      tick();
    end
    chk("nolim_sat", 32'(dut_c.hold_q), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
